// File: rtl/nn_layer_pkg.sv
// Shared types and arithmetic helpers for the dense neural-network layer.
// Build option: define NN_LAYER_SAT_EN to make the DATA_W reduction saturate
// instead of wrapping.
package nn_layer_pkg;

  // Activation applied to each neuron after the bias add.
  typedef enum logic [0:0] {
    ACT_IDENT = 1'b0,
    ACT_RELU  = 1'b1
  } act_e;

  // Layer control states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_BIAS,
    ST_ACT,
    ST_DONE
  } state_e;

`ifdef NN_LAYER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Working width for the reduction helper; every layer intermediate fits in it.
  localparam int CALC_W = 64;

  // Reduce a signed value to out_w bits: clamp when sat is set, otherwise keep
  // the low out_w bits as a two's-complement value. Result is sign-extended.
  function automatic logic signed [CALC_W-1:0] sat_trunc(
    input logic signed [CALC_W-1:0] val,
    input int                       out_w,
    input bit                       sat
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    logic signed [CALC_W-1:0] res;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sat) begin
      if (val > hi)      res = hi;
      else if (val < lo) res = lo;
      else               res = val;
    end else begin
      res = (val <<< (CALC_W - out_w)) >>> (CALC_W - out_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One neuron of the dense layer: multiply-accumulate over the input vector,
// bias add with DATA_W reduction, then the activation stage.
// Reduction mode follows NN_LAYER_SAT_EN (see nn_layer_pkg).
module nn_mac_lane
  import nn_layer_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter int   FRAC_W   = 4,
  parameter int   N_IN     = 2,
  parameter act_e ACT_MODE = ACT_IDENT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_acc_i,  // first element accepted
  input  logic                     acc_en_i,   // later element accepted
  input  logic                     bias_en_i,  // BIAS state
  input  logic                     act_en_i,   // ACT state
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] y_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(N_IN);
  localparam int Z_W    = ACC_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [Z_W-1:0]    z_full;
  logic signed [DATA_W-1:0] z_q, z_d;
  logic signed [DATA_W-1:0] y_q, y_d;

  // Next-state for accumulator, reduced pre-activation value and output.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    acc_d = acc_q;
    z_d   = z_q;
    y_d   = y_q;

    prod   = PROD_W'(x_i) * PROD_W'(w_i);
    z_full = Z_W'(acc_q >>> FRAC_W) + Z_W'(b_i);

    if (clr_acc_i)     acc_d = ACC_W'(prod);
    else if (acc_en_i) acc_d = acc_q + ACC_W'(prod);

    if (bias_en_i) z_d = DATA_W'(sat_trunc(CALC_W'(z_full), DATA_W, SAT_EN));

    if (act_en_i) begin
      if (ACT_MODE == ACT_RELU && z_q[DATA_W-1]) y_d = '0;
      else                                       y_d = z_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: accumulators are plain registers, so they take the async reset; the
    // weight/bias ROM is constant and needs none.
    if (rst) begin
      acc_q <= '0;
      z_q   <= '0;
      y_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      acc_q <= acc_d;
      z_q   <= z_d;
      y_q   <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/nn_dense_layer.sv
// Fully-connected layer: streams N_IN signed elements in, runs N_OUT parallel
// MAC lanes against a constant weight ROM, adds biases, applies the activation
// and hands the packed result vector downstream over valid/ready.
// Weight/bias ROM contents are packed parameters in neuron-major order
// (word j*N_IN+i = w[j][i], at bits [(j*N_IN+i)*DATA_W +: DATA_W]).
// Build option: NN_LAYER_SAT_EN selects saturating reduction (default wraps).
module nn_dense_layer
  import nn_layer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int ACT    = 0,
  parameter logic [N_OUT*N_IN*DATA_W-1:0] W_INIT = '0,
  parameter logic [N_OUT*DATA_W-1:0]      B_INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_rdy,
  output logic                     out_vld,
  output logic [N_OUT*DATA_W-1:0]  out_data,
  input  logic                     out_rdy,
  output logic                     busy
);

  localparam int               CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_IN - 1);

  state_e           state_q;
  logic [CNT_W-1:0] in_cnt_q;
  logic             out_vld_q;
  logic             busy_q;
  logic             accept;

  assign in_rdy  = ((state_q == ST_IDLE) || (state_q == ST_ACCUM)) && !rst;
  assign accept  = in_vld && in_rdy;
  assign out_vld = out_vld_q;
  assign busy    = busy_q;

  // Vector sequencing: element count, state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (N_IN == 1) begin
              state_q <= ST_BIAS;
            end else begin
              state_q  <= ST_ACCUM;
              in_cnt_q <= CNT_W'(1);
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            if (in_cnt_q == LAST) begin
              in_cnt_q <= '0;
              state_q  <= ST_BIAS;
            end else begin
              in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_BIAS: state_q <= ST_ACT;
        ST_ACT: begin
          state_q   <= ST_DONE;
          out_vld_q <= 1'b1;
        end
        ST_DONE: begin
          // The element handshake is blocked here (in_rdy=0), so a concurrent
          // in_vld is only taken once back in IDLE.
          if (out_rdy) begin
            state_q   <= ST_IDLE;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    logic signed [DATA_W-1:0] w_sel;
    logic signed [DATA_W-1:0] b_sel;

    assign w_sel = W_INIT[(j * N_IN + int'(in_cnt_q)) * DATA_W +: DATA_W];
    assign b_sel = B_INIT[j * DATA_W +: DATA_W];

    nn_mac_lane #(
      .DATA_W   (DATA_W),
      .FRAC_W   (FRAC_W),
      .N_IN     (N_IN),
      .ACT_MODE (act_e'(ACT))
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr_acc_i (accept && (state_q == ST_IDLE)),
      .acc_en_i  (accept && (state_q == ST_ACCUM)),
      .bias_en_i (state_q == ST_BIAS),
      .act_en_i  (state_q == ST_ACT),
      .x_i       (in_data),
      .w_i       (w_sel),
      .b_i       (b_sel),
      .y_o       (out_data[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_nn_dense_layer.sv
// Self-checking bench for nn_dense_layer: three instances (identity, ReLU, and
// a large-weight identity layer) share one input stream and one output handshake.
`timescale 1ns/1ps
module tb_nn_dense_layer;

  // w0=(16,32) b0=8, w1=(-16,-16) b1=0
  localparam logic [31:0] W_MAIN = {8'hF0, 8'hF0, 8'h20, 8'h10};
  // w0=(127,127) b0=8, w1=(-16,-16) b1=0
  localparam logic [31:0] W_BIG  = {8'hF0, 8'hF0, 8'h7F, 8'h7F};
  localparam logic [15:0] B_ALL  = {8'h00, 8'h08};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_vld = 1'b0;
  logic              out_rdy = 1'b1;
  logic signed [7:0] in_data = '0;

  logic        rdy_i, rdy_r, rdy_b;
  logic        vld_i, vld_r, vld_b;
  logic        busy_i, busy_r, busy_b;
  logic [15:0] od_i, od_r, od_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nn_dense_layer #(.DATA_W(8), .FRAC_W(4), .N_IN(2), .N_OUT(2), .ACT(0),
                   .W_INIT(W_MAIN), .B_INIT(B_ALL)) dut_id (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(rdy_i),
    .out_vld(vld_i), .out_data(od_i), .out_rdy(out_rdy), .busy(busy_i));

  nn_dense_layer #(.DATA_W(8), .FRAC_W(4), .N_IN(2), .N_OUT(2), .ACT(1),
                   .W_INIT(W_MAIN), .B_INIT(B_ALL)) dut_relu (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(rdy_r),
    .out_vld(vld_r), .out_data(od_r), .out_rdy(out_rdy), .busy(busy_r));

  nn_dense_layer #(.DATA_W(8), .FRAC_W(4), .N_IN(2), .N_OUT(2), .ACT(0),
                   .W_INIT(W_BIG), .B_INIT(B_ALL)) dut_big (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(rdy_b),
    .out_vld(vld_b), .out_data(od_b), .out_rdy(out_rdy), .busy(busy_b));

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic longint lane(input logic [15:0] d, input int j);
    logic signed [7:0] t;
    t = d[j*8 +: 8];
    return longint'(t);
  endfunction

  function automatic longint reduce(input longint z);
`ifdef NN_LAYER_SAT_EN
    if (z > 127)  return 127;
    if (z < -128) return -128;
    return z;
`else
    logic signed [7:0] t;
    t = z[7:0];
    return longint'(t);
`endif
  endfunction

  function automatic longint model(input longint x0, input longint x1, input longint w0,
                                   input longint w1, input longint b, input bit relu);
    longint acc, z;
    acc = x0 * w0 + x1 * w1;
    z   = reduce((acc >>> 4) + b);
    if (relu && z < 0) z = 0;
    return z;
  endfunction

  // Present one element from a negedge and return just after the accepting edge.
  task automatic send(input logic signed [7:0] x);
    int n;
    @(negedge clk);
    in_vld  = 1'b1;
    in_data = x;
    n = 0;
    while (!rdy_i && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_i) timeout("send");
    @(posedge clk);
  endtask

  // Drop in_vld and count negedges until out_vld (lat=3 right after the last accept).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      in_vld = 1'b0;
      lat++;
    end while (!vld_i && lat < 20);
    if (!vld_i) timeout("wait_out");
  endtask

  // Expects out_rdy=1 at the current negedge: next edge completes the handshake.
  task automatic after_handshake(input string tag);
    @(negedge clk);
    check({tag, "_vld_low"}, vld_i, 0);
    check({tag, "_busy_low"}, busy_i, 0);
    check({tag, "_rdy_high"}, rdy_i, 1);
  endtask

  typedef struct {
    logic signed [7:0] x0, x1;
    longint id0, id1, re0, re1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tbl[0] = '{x0: 16,  x1: 16, id0: 56, id1: -32, re0: 56, re1: 0};
    tbl[1] = '{x0: -16, x1: 16, id0: 24, id1: 0,   re0: 24, re1: 0};
    tbl[2] = '{x0: 16,  x1: -16, id0: -8, id1: 0,  re0: 0,  re1: 0};
    tbl[3] = '{x0: -20, x1: 3,  id0: -6, id1: 17,  re0: 0,  re1: 17};
    tbl[4] = '{x0: 0,   x1: 0,  id0: 8,  id1: 0,   re0: 8,  re1: 0};
    tbl[5] = '{x0: 5,   x1: -7, id0: -1, id1: 2,   re0: 0,  re1: 2};

    // Reset state
    #2;
    check("rst_out_vld", vld_i, 0);
    check("rst_out_data", od_i, 0);
    check("rst_busy", busy_i, 0);
    check("rst_in_rdy", rdy_i, 0);
    check("rst_relu_data", od_r, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_rdy", rdy_i, 1);

    // Table-driven vectors, out_rdy held high
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].x0);
      #1;
      check($sformatf("tbl%0d_busy", i), busy_i, 1);
      send(tbl[i].x1);
      wait_out(lat);
      check($sformatf("tbl%0d_latency", i), lat, 3);
      check($sformatf("tbl%0d_id0", i), lane(od_i, 0), tbl[i].id0);
      check($sformatf("tbl%0d_id1", i), lane(od_i, 1), tbl[i].id1);
      check($sformatf("tbl%0d_relu0", i), lane(od_r, 0), tbl[i].re0);
      check($sformatf("tbl%0d_relu1", i), lane(od_r, 1), tbl[i].re1);
      check($sformatf("tbl%0d_rdy_done", i), rdy_i, 0);
      check($sformatf("tbl%0d_other_vld", i), {vld_r, vld_b}, 3);
      after_handshake($sformatf("tbl%0d", i));
    end

    // Overflowing accumulation: reduction to 8 bits
    send(8'sd127);
    send(8'sd127);
    wait_out(lat);
`ifdef NN_LAYER_SAT_EN
    check("big_lane0", lane(od_b, 0), 127);
    check("big_lane1", lane(od_b, 1), -128);
`else
    check("big_lane0", lane(od_b, 0), -24);
    check("big_lane1", lane(od_b, 1), 2);
`endif
    check("big_id0", lane(od_i, 0), model(127, 127, 16, 32, 8, 0));
    after_handshake("big");

    // Back-pressure in DONE with in_vld asserted
    out_rdy = 1'b0;
    send(8'sd16);
    send(8'sd16);
    wait_out(lat);
    in_vld  = 1'b1;
    in_data = 8'sd99;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_lane0", k), lane(od_i, 0), 56);
      check($sformatf("stall%0d_lane1", k), lane(od_i, 1), -32);
      check($sformatf("stall%0d_in_rdy", k), rdy_i, 0);
      check($sformatf("stall%0d_out_vld", k), vld_i, 1);
      @(negedge clk);
    end
    in_data = 8'sd16;
    out_rdy = 1'b1;
    after_handshake("stall_hs");
    @(posedge clk);
    #1;
    check("stall_next_accept", busy_i, 1);
    send(8'sd16);
    wait_out(lat);
    check("stall_next_latency", lat, 3);
    check("stall_next_lane0", lane(od_i, 0), 56);
    check("stall_next_lane1", lane(od_i, 1), -32);
    after_handshake("stall_next");

    // Reset after first accept
    send(8'sd100);
    #1;
    check("abort_busy", busy_i, 1);
    @(negedge clk);
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_busy_rst", busy_i, 0);
    check("abort_rdy_rst", rdy_i, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'sd16);
    send(8'sd16);
    wait_out(lat);
    check("abort_lane0", lane(od_i, 0), 56);
    check("abort_lane1", lane(od_i, 1), -32);
    after_handshake("abort");

    // Reset while holding a result in DONE: out_vld drops without a clock edge
    out_rdy = 1'b0;
    send(8'sd16);
    send(8'sd16);
    wait_out(lat);
    #2;
    rst = 1'b1;
    #1;
    check("done_rst_vld", vld_i, 0);
    check("done_rst_data", od_i, 0);
    @(negedge clk);
    rst = 1'b0;
    out_rdy = 1'b1;

    // Random vectors with input gaps and output stalls
    for (int v = 0; v < 100; v++) begin
      logic signed [7:0] x0, x1;
      int g, hold;
      x0 = 8'($urandom_range(0, 255));
      x1 = 8'($urandom_range(0, 255));
      out_rdy = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 3);
      g = $urandom_range(0, 2);
      if (g > 0) begin
        @(negedge clk);
        in_vld = 1'b0;
        repeat (g - 1) @(negedge clk);
      end
      send(x0);
      #1;
      check($sformatf("rnd%0d_busy", v), busy_i, 1);
      g = $urandom_range(0, 2);
      if (g > 0) begin
        @(negedge clk);
        in_vld = 1'b0;
        repeat (g - 1) @(negedge clk);
      end
      send(x1);
      wait_out(lat);
      check($sformatf("rnd%0d_id0", v), lane(od_i, 0), model(x0, x1, 16, 32, 8, 0));
      check($sformatf("rnd%0d_id1", v), lane(od_i, 1), model(x0, x1, -16, -16, 0, 0));
      check($sformatf("rnd%0d_relu0", v), lane(od_r, 0), model(x0, x1, 16, 32, 8, 1));
      check($sformatf("rnd%0d_relu1", v), lane(od_r, 1), model(x0, x1, -16, -16, 0, 1));
      check($sformatf("rnd%0d_big0", v), lane(od_b, 0), model(x0, x1, 127, 127, 8, 0));
      check($sformatf("rnd%0d_big1", v), lane(od_b, 1), model(x0, x1, -16, -16, 0, 0));
      if (!out_rdy) begin
        repeat (hold) @(negedge clk);
        check($sformatf("rnd%0d_busy_stall", v), busy_i, 1);
        out_rdy = 1'b1;
      end
      after_handshake($sformatf("rnd%0d", v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
